// File: rtl/npc_exec_core.sv
// npc_exec_core: execute/writeback slice of the single-cycle NPC core.
// Contains a 32-entry register file with two combinational read ports and
// one clocked write port, an 8-way one-hot AND-OR result selector, and a
// 3-to-8 one-hot funct3 decoder.
// Optional feature macro: NPC_EXEC_TRACE_EN prints one line per write
// attempt (including discarded x0 writes). It is simulation-only and does
// not change functional behaviour.
module npc_exec_core #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,      // asynchronous, active-low
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [7:0]      alu_op,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] alu_result,
  input  logic [2:0]      funct3,
  output logic [7:0]      funct3_hot
);

  localparam int NREG = 2 ** AW;
  localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);

  // One-hot operation positions within alu_op.
  localparam int OP_AUIPC = 0;
  localparam int OP_LUI   = 1;
  localparam int OP_JAL   = 2;
  localparam int OP_JALR  = 3;
  localparam int OP_ADDI  = 4;
  localparam int OP_ADD   = 5;
  localparam int OP_LW    = 6;
  localparam int OP_LBU   = 7;

  // Entry 0 is never written and never read; x0 is forced to zero at the
  // read mux instead.
  logic [XLEN-1:0] rf_q [NREG];

  // Write-port qualification: x0 writes are discarded.
  logic wr_en_d;
  assign wr_en_d = wen && (waddr != '0);

  // Register file state: async clear, then one write per rising edge.
  // Reset being the async branch makes it dominate any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      rf_q[waddr] <= alu_result;
    end
  end

  // Combinational reads with no write bypass; index 0 always reads zero.
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : rf_q[raddr2];
  end

  // Candidate result terms; all additions wrap modulo 2**XLEN.
  logic [XLEN-1:0] pc_imm_sum;
  logic [XLEN-1:0] pc_link;
  logic [XLEN-1:0] rs1_imm_sum;
  logic [XLEN-1:0] rs1_rs2_sum;
  logic [XLEN-1:0] lbu_data;

  assign pc_imm_sum  = pc + imm;
  assign pc_link     = pc + LINK_OFS;
  assign rs1_imm_sum = rdata1 + imm;
  assign rs1_rs2_sum = rdata1 + rdata2;
  assign lbu_data    = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};

  // AND-OR result selector: an empty alu_op yields zero, a multi-hot one
  // yields the OR of the selected terms.
  always_comb begin
    alu_result = ({XLEN{alu_op[OP_AUIPC]}} & pc_imm_sum)
               | ({XLEN{alu_op[OP_LUI]}}   & imm)
               | ({XLEN{alu_op[OP_JAL]}}   & pc_link)
               | ({XLEN{alu_op[OP_JALR]}}  & pc_link)
               | ({XLEN{alu_op[OP_ADDI]}}  & rs1_imm_sum)
               | ({XLEN{alu_op[OP_ADD]}}   & rs1_rs2_sum)
               | ({XLEN{alu_op[OP_LW]}}    & mem_rdata)
               | ({XLEN{alu_op[OP_LBU]}}   & lbu_data);
  end

  // funct3 one-hot decode; independent of reset.
  always_comb begin
    funct3_hot = 8'b0000_0001 << funct3;
  end

`ifdef NPC_EXEC_TRACE_EN
  // Trace every write attempt, marking the ones aimed at x0.
  always_ff @(posedge clk) begin
    if (reset && wen) begin
      $display("npc_exec_core trace: rd=x%0d result=%08h alu_op=%02h mem_rdata=%08h%s",
               waddr, alu_result, alu_op, mem_rdata,
               (waddr == '0) ? " (x0 write discarded)" : "");
    end
  end
`else
  // No trace logic in the default build.
`endif

endmodule

// File: tb/tb_npc_exec_core.sv
// Testbench for npc_exec_core: directed vectors from the test plan plus a
// random tail, checked through an expected-value queue against a small
// behavioural register/ALU model kept by the bench.
module tb_npc_exec_core;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        wen;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [7:0]  alu_op;
  logic [31:0] imm, pc, mem_rdata, alu_result;
  logic [2:0]  funct3;
  logic [7:0]  funct3_hot;

  npc_exec_core #(.XLEN(32), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .alu_op     (alu_op),
    .imm        (imm),
    .pc         (pc),
    .mem_rdata  (mem_rdata),
    .alu_result (alu_result),
    .funct3     (funct3),
    .funct3_hot (funct3_hot)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  logic [31:0] model_rf [32];
  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%08h expected=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model_rf[a];
  endfunction

  // Reference result for legal (zero or one-hot) alu_op values.
  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [31:0] im,
                                            input logic [31:0] p, input logic [31:0] md);
    case (op)
      8'h01:   return p + im;
      8'h02:   return im;
      8'h04:   return p + 32'd4;
      8'h08:   return p + 32'd4;
      8'h10:   return s1 + im;
      8'h20:   return s1 + s2;
      8'h40:   return md;
      8'h80:   return {24'h0, md[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
  endtask

  // ---------------- driver ----------------
  // Drives one instruction at the falling edge, checks the settled outputs
  // before the rising edge, then commits the write into the model.
  task automatic step(input logic w, input logic [4:0] wa, input logic [4:0] ra1,
                      input logic [4:0] ra2, input logic [7:0] op, input logic [31:0] im,
                      input logic [31:0] p, input logic [31:0] md, input logic [2:0] f3);
    logic [31:0] exp_alu;
    logic [7:0]  hot;
    @(negedge clk);
    wen = w; waddr = wa; raddr1 = ra1; raddr2 = ra2;
    alu_op = op; imm = im; pc = p; mem_rdata = md; funct3 = f3;
    exp_alu = model_alu(op, model_read(ra1), model_read(ra2), im, p, md);
    hot = 8'h01 << f3;
    exp_q.push_back(exp_alu);
    exp_q.push_back(model_read(ra1));
    exp_q.push_back(model_read(ra2));
    exp_q.push_back({24'h0, hot});
    #2;
    check("alu_result", alu_result, exp_q.pop_front());
    check("rdata1", rdata1, exp_q.pop_front());
    check("rdata2", rdata2, exp_q.pop_front());
    check("funct3_hot", {24'h0, funct3_hot}, exp_q.pop_front());
    @(posedge clk);
    if (w && wa != 5'd0) model_rf[wa] = exp_alu;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    wen = 1'b0; waddr = '0; raddr1 = 5'd7; raddr2 = 5'd31;
    alu_op = '0; imm = '0; pc = '0; mem_rdata = '0; funct3 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // addi / add with wrap-around
    step(1'b1, 5'd1, 5'd0, 5'd0, 8'h10, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'd0);
    step(1'b1, 5'd2, 5'd1, 5'd1, 8'h20, 32'h0, 32'h0, 32'h0, 3'd0);
    step(1'b0, 5'd0, 5'd2, 5'd1, 8'h00, 32'h0, 32'h0, 32'h0, 3'd0);

    // x0 write is discarded
    step(1'b1, 5'd0, 5'd0, 5'd0, 8'h02, 32'hDEAD_B000, 32'h0, 32'h0, 3'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 32'h0, 32'h0, 32'h0, 3'd0);

    // pc-relative ops
    step(1'b0, 5'd0, 5'd0, 5'd0, 8'h01, 32'h0000_1000, 32'h8000_0000, 32'h0, 3'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 8'h04, 32'h0000_1000, 32'h8000_0000, 32'h0, 3'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 8'h08, 32'h0000_1000, 32'h8000_0000, 32'h0, 3'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 8'h04, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0);

    // loads; a same-cycle read of x3 sees the previous value
    step(1'b1, 5'd3, 5'd3, 5'd0, 8'h40, 32'h0, 32'h0, 32'hA5B6_C7D8, 3'd0);
    step(1'b1, 5'd3, 5'd3, 5'd0, 8'h80, 32'h0, 32'h0, 32'hA5B6_C7D8, 3'd0);
    step(1'b0, 5'd0, 5'd3, 5'd3, 8'h00, 32'h0, 32'h0, 32'h0, 3'd0);

    // funct3 sweep with alu_op = 0
    for (int f = 0; f < 8; f++) begin
      step(1'b0, 5'd0, 5'd1, 5'd2, 8'h00, 32'h1234_5678, 32'h4000_0000, 32'hFFFF_FFFF, 3'(f));
    end

    // asynchronous reset between edges, and reset dominating a write
    step(1'b1, 5'd5, 5'd0, 5'd0, 8'h02, 32'h0000_1234, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    wen = 1'b0; raddr1 = 5'd5; raddr2 = 5'd3; alu_op = 8'h00;
    #1;
    check("pre_reset_x5", rdata1, model_read(5'd5));
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_x5", rdata1, 32'h0);
    check("async_reset_x3", rdata2, 32'h0);
    model_clear();
    @(negedge clk);
    wen = 1'b1; waddr = 5'd5; alu_op = 8'h02; imm = 32'h0000_0055;
    @(posedge clk);
    #1;
    check("reset_blocks_write", rdata1, 32'h0);
    @(negedge clk);
    wen = 1'b0;
    reset = 1'b1;
    #1;
    check("post_reset_x5", rdata1, 32'h0);

    // random tail: legal one-hot or zero alu_op
    for (int n = 0; n < 60; n++) begin
      logic [7:0] op;
      int sel;
      sel = $urandom_range(0, 8);
      op = (sel == 8) ? 8'h00 : 8'(1 << sel);
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), op,
           $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)));
    end

    if (exp_q.size() != 0) begin
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/npc_exec_core.md
Name: npc_exec_core

Overview:
- Execute/writeback slice of the single-cycle NPC core. It contains:
  - a 32-entry integer register file with two combinational read ports and one clocked write port;
  - an 8-way one-hot ALU/result selector;
  - a 3-to-8 one-hot funct3 decoder.
- Sits between the instruction decoder (supplies addresses, imm, alu_op, funct3) and memory (supplies load data).
- ALU result is both the block output and the register write data.

Parameters:
- XLEN, 32, datapath width in bits.
- AW, 5, register address width (2**AW registers).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wen  input  1  register write enable.
- waddr  input  AW  destination register (rd).
- raddr1  input  AW  source register 1 (rs1).
- raddr2  input  AW  source register 2 (rs2).
- rdata1  output  XLEN  contents of raddr1 (src1).
- rdata2  output  XLEN  contents of raddr2 (src2).
- alu_op  input  8  one-hot op select: bit0 auipc, 1 lui, 2 jal, 3 jalr, 4 addi, 5 add, 6 lw, 7 lbu.
- imm  input  XLEN  decoded, sign-extended immediate.
- pc  input  XLEN  address of the current instruction.
- mem_rdata  input  XLEN  load data from memory.
- alu_result  output  XLEN  selected result; also the register write data.
- funct3  input  3  instruction funct3 field.
- funct3_hot  output  8  one-hot decode of funct3.

Behaviour:
- Register file
  - Asynchronous reset: while reset=0, all 32 registers are forced to 0 immediately, independent of clk.
  - Reset dominates any write pending in the same cycle.
- Reads are purely combinational. Index 0 always reads 0.
- Write
  - On rising clk, if reset=1, wen=1 and waddr!=0: reg[waddr] <= alu_result.
  - Writes to x0 are discarded.
- No write-to-read bypass. A same-cycle read of the register being written returns the old value; the new value is visible after the edge.
- Single-cycle: every write is committed at the first edge after its inputs settle.
- ALU result is combinational, formed as an AND-OR of the selected terms:
  - auipc: pc + imm
  - lui: imm
  - jal and jalr: pc + 4 (link value)
  - addi: rdata1 + imm
  - add: rdata1 + rdata2
  - lw: mem_rdata
  - lbu: {24'b0, mem_rdata[7:0]} (zero-extended)
- ALU arithmetic and select edge cases:
  - All additions are modulo 2**XLEN; overflow and carry are ignored.
  - alu_op = 0 gives alu_result = 0.
  - A multi-hot alu_op is illegal. The output is then the bitwise OR of the selected terms and carries no further guarantee.
- funct3 decoder: funct3_hot = 1 << funct3, exactly one bit set for every input. Purely combinational; reset does not affect it.
- Reset does not affect any combinational output except through the cleared register contents: rdata1/rdata2 read 0 during and after reset until rewritten.

Optional Feature:
- Macro: NPC_EXEC_TRACE_EN.
- Defined: on each rising clk with reset=1 and wen=1, the block prints one simulation line containing waddr, alu_result (8 hex digits), alu_op and mem_rdata. This includes writes to x0, which are marked as discarded.
- Not defined: no print logic is compiled; functional behaviour is identical in both cases.

Test Plan:
- Reset: write reg5=0x1234, then pulse reset low between clock edges -> rdata1 (raddr1=5) reads 0 immediately, before the next edge.
- addi/add: wen=1, waddr=1, alu_op=bit4, raddr1=0, imm=0xFFFFFFFF -> reg1=0xFFFFFFFF. Then waddr=2, alu_op=bit5, raddr1=1, raddr2=1 -> reg2=0xFFFFFFFE (wrap-around).
- x0 write: wen=1, waddr=0, alu_op=bit1, imm=0xDEADB000 -> alu_result=0xDEADB000; rdata1 with raddr1=0 stays 0.
- PC ops: pc=0x80000000, imm=0x00001000. alu_op=bit0 -> 0x80001000; bit2 -> 0x80000004; bit3 -> 0x80000004. pc=0xFFFFFFFC with bit2 -> 0x00000000.
- Loads: mem_rdata=0xA5B6C7D8. alu_op=bit6 -> 0xA5B6C7D8; bit7 -> 0x000000D8. With waddr=3, reg3 updates only at the next edge; a same-cycle read of reg3 returns the old value.
- funct3 decoder: sweep funct3 0..7 -> funct3_hot = 0x01, 0x02, 0x04, ... 0x80. alu_op=0 -> alu_result=0.
